loa_accum_pipe: RTL and testbench

Multi-lane streaming accumulator built on the lower-part-OR approximate adder. Each lane sums a framed stream of signed operands into a wide accumulator. The number of approximated LSBs is selectable at run time per frame, so precision can be traded for power without re-synthesis. It sits at the output edge of a systolic array column and reduces partial sums before write-back, with valid/ready handshakes on both sides.

---
 rtl/loa_pkg.sv | 30 +++
 rtl/loa_add_dyn.sv | 29 ++
 rtl/loa_accum_pipe.sv | 130 +++++++++++++
 tb/tb_loa_accum_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loa_pkg.sv
// Shared types and helpers for the lower-part-OR accumulator pipeline.
package loa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } loa_state_e;

   localparam int LOA_LIMIT_W = 64;

   function automatic int loa_clamp_k(input int sel, input int max_k);
      return (sel > max_k) ? max_k : sel;
   endfunction

   // Most positive two's-complement value of width w, in the low w bits.
   function automatic logic [LOA_LIMIT_W-1:0] loa_sat_max(input int w);
      logic [LOA_LIMIT_W-1:0] m;
      m = '0;
      for (int i = 0; i < LOA_LIMIT_W; i++) begin
         if (i < w - 1) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [LOA_LIMIT_W-1:0] loa_sat_min(input int w);
      return LOA_LIMIT_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/loa_add_dyn.sv
// Combinational lower-part-OR adder: the low k bits are ORed, the rest added
// exactly with a carry-in of a[k-1] & b[k-1]; k = 0 is an exact add.
module loa_add_dyn #(
   parameter int W  = 32,
   parameter int KW = 4
) (
   input  logic [W-1:0]  a_i,
   input  logic [W-1:0]  b_i,
   input  logic [KW-1:0] k_i,
   output logic [W-1:0]  sum_o,
   output logic          ovf_o
);

   logic [W-1:0] mask;
   logic [W-1:0] cbit;
   logic [W-1:0] hi;
   logic         carry;

   always_comb begin
      mask  = (W'(1) << k_i) - W'(1);
      // Top bit of the approximated field; all zero when k = 0.
      cbit  = mask ^ (mask >> 1);
      carry = |(a_i & b_i & cbit);
      hi    = (a_i & ~mask) + (b_i & ~mask) + (carry ? (cbit << 1) : '0);
      sum_o = hi | ((a_i | b_i) & mask);
      ovf_o = (a_i[W-1] == b_i[W-1]) && (sum_o[W-1] != a_i[W-1]);
   end

endmodule

// File: rtl/loa_accum_pipe.sv
// Multi-lane framed accumulator using LOA adders with per-frame k.
// Optional saturation is enabled with the LOA_ACCUM_SAT_EN macro.
module loa_accum_pipe
   import loa_pkg::*;
#(
   parameter  int LANES      = 4,
   parameter  int IN_WIDTH   = 16,
   parameter  int ACC_WIDTH  = 32,
   parameter  int MAX_IGNORE = 8,
   localparam int KW         = $clog2(MAX_IGNORE + 1)
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [KW-1:0]                IGNORE_SEL,
   input  logic                         IN_VALID,
   output logic                         IN_READY,
   input  logic                         IN_FIRST,
   input  logic                         IN_LAST,
   input  logic [LANES*IN_WIDTH-1:0]    IN_DATA,
   output logic                         OUT_VALID,
   input  logic                         OUT_READY,
   output logic [LANES*ACC_WIDTH-1:0]   OUT_DATA,
   output logic [LANES-1:0]             OUT_SAT,
   output logic                         BUSY,
   output logic [1:0]                   STATE_DBG
);

   // Handshake: a beat moves when IN_VALID && IN_READY at a rising CLK; a
   // result moves when OUT_VALID && OUT_READY. Neither side may retract
   // valid data based on the other side's ready.

   loa_state_e state_q, state_d;
   logic [LANES-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
   logic [LANES-1:0][ACC_WIDTH-1:0] lane_ext;
   logic [LANES-1:0][ACC_WIDTH-1:0] lane_sum;
   logic [LANES-1:0]                lane_ovf;
   logic [LANES-1:0]                sat_q, sat_d;
   logic [KW-1:0]                   k_q, k_d;
   logic                            rdy_q;
   logic                            accept;
   logic                            start;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_ext[i] = ACC_WIDTH'($signed(IN_DATA[i*IN_WIDTH +: IN_WIDTH]));

      loa_add_dyn #(
         .W  (ACC_WIDTH),
         .KW (KW)
      ) u_add (
         .a_i   (acc_q[i]),
         .b_i   (lane_ext[i]),
         .k_i   (k_q),
         .sum_o (lane_sum[i]),
         .ovf_o (lane_ovf[i])
      );
   end

`ifdef LOA_ACCUM_SAT_EN
   localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(loa_sat_max(ACC_WIDTH));
   localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(loa_sat_min(ACC_WIDTH));
`else
   logic unused_ovf;
   assign unused_ovf = ^lane_ovf;
`endif

   // rdy_q keeps IN_READY low through reset and the first clock after it.
   assign IN_READY  = rdy_q && ((state_q != ST_HOLD) || OUT_READY);
   assign accept    = IN_VALID && IN_READY;
   assign start     = accept && IN_FIRST;
   assign OUT_VALID = (state_q == ST_HOLD);
   assign BUSY      = (state_q != ST_IDLE);
   assign OUT_DATA  = acc_q;
   assign OUT_SAT   = sat_q;
   assign STATE_DBG = state_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      k_d     = k_q;

      case (state_q)
         ST_IDLE:  if (start) state_d = IN_LAST ? ST_HOLD : ST_ACCUM;
         ST_ACCUM: if (accept && IN_LAST) state_d = ST_HOLD;
         ST_HOLD: begin
            if (OUT_READY) begin
               if (start) state_d = IN_LAST ? ST_HOLD : ST_ACCUM;
               else       state_d = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase

      if (start) begin
         acc_d = lane_ext;
         sat_d = '0;
         k_d   = KW'(loa_clamp_k(int'(IGNORE_SEL), MAX_IGNORE));
      end else if (accept && (state_q == ST_ACCUM)) begin
         for (int i = 0; i < LANES; i++) begin
`ifdef LOA_ACCUM_SAT_EN
            if (lane_ovf[i]) begin
               acc_d[i] = acc_q[i][ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
               sat_d[i] = 1'b1;
            end else begin
               acc_d[i] = lane_sum[i];
            end
`else
            acc_d[i] = lane_sum[i];
`endif
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         sat_q   <= '0;
         k_q     <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         k_q     <= k_d;
         rdy_q   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_loa_accum_pipe.sv
// Directed scoreboard bench for loa_accum_pipe (default 4x16->32 instance and
// a 1-lane 16->16 instance for the overflow boundary).
module tb_loa_accum_pipe;

   logic         clk;
   logic         rst;
   logic [3:0]   ign_sel;
   logic         in_valid, in_first, in_last;
   logic         in_ready;
   logic [63:0]  in_data;
   logic         out_valid, out_ready;
   logic [127:0] out_data;
   logic [3:0]   out_sat;
   logic         busy;
   logic [1:0]   state_dbg;

   logic [3:0]   s_ign_sel;
   logic         s_in_valid, s_in_first, s_in_last;
   logic         s_in_ready;
   logic [15:0]  s_in_data;
   logic         s_out_valid, s_out_ready;
   logic [15:0]  s_out_data;
   logic [0:0]   s_out_sat;
   logic         s_busy;
   logic [1:0]   s_state_dbg;

   int n_vec = 0;
   int n_err = 0;

   logic [127:0] exp_q[$];
   logic [3:0]   exp_sat_q[$];
   logic [15:0]  exp2_q[$];
   logic [0:0]   exp2_sat_q[$];

   loa_accum_pipe dut (
      .CLK(clk), .RST(rst), .IGNORE_SEL(ign_sel),
      .IN_VALID(in_valid), .IN_READY(in_ready), .IN_FIRST(in_first), .IN_LAST(in_last),
      .IN_DATA(in_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .OUT_DATA(out_data), .OUT_SAT(out_sat), .BUSY(busy), .STATE_DBG(state_dbg)
   );

   loa_accum_pipe #(
      .LANES(1), .IN_WIDTH(16), .ACC_WIDTH(16), .MAX_IGNORE(8)
   ) dut_narrow (
      .CLK(clk), .RST(rst), .IGNORE_SEL(s_ign_sel),
      .IN_VALID(s_in_valid), .IN_READY(s_in_ready), .IN_FIRST(s_in_first), .IN_LAST(s_in_last),
      .IN_DATA(s_in_data), .OUT_VALID(s_out_valid), .OUT_READY(s_out_ready),
      .OUT_DATA(s_out_data), .OUT_SAT(s_out_sat), .BUSY(s_busy), .STATE_DBG(s_state_dbg)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] pk(input logic [15:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [127:0] ex(input logic [31:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic beat(input logic [63:0] d, input logic f, input logic l, input logic [3:0] sel);
      int guard;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_first = f; in_last = l; ign_sel = sel;
      #1;
      while (!in_ready && guard < 50) begin
         @(negedge clk); #1; guard++;
      end
      if (!in_ready) begin
         n_vec++; n_err++;
         $display("FAIL beat_timeout: got in_ready=0 expected 1");
      end
      @(posedge clk);
   endtask

   task automatic idle_in();
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
   endtask

   task automatic beat2(input logic [15:0] d, input logic f, input logic l);
      int guard;
      guard = 0;
      @(negedge clk);
      s_in_valid = 1'b1; s_in_data = d; s_in_first = f; s_in_last = l; s_ign_sel = 4'd0;
      #1;
      while (!s_in_ready && guard < 50) begin
         @(negedge clk); #1; guard++;
      end
      if (!s_in_ready) begin
         n_vec++; n_err++;
         $display("FAIL beat2_timeout: got in_ready=0 expected 1");
      end
      @(posedge clk);
   endtask

   // monitors: compare whenever a result is presented; pop on handshake
   always @(negedge clk) begin
      #2;
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: got %0h expected no result", out_data);
         end else begin
            check("out_data", out_data, exp_q[0]);
            check("out_sat", 128'(out_sat), 128'(exp_sat_q[0]));
            if (out_ready) begin
               void'(exp_q.pop_front());
               void'(exp_sat_q.pop_front());
            end
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (!rst && s_out_valid) begin
         if (exp2_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output2: got %0h expected no result", s_out_data);
         end else begin
            check("narrow_data", 128'(s_out_data), 128'(exp2_q[0]));
            check("narrow_sat", 128'(s_out_sat), 128'(exp2_sat_q[0]));
            if (s_out_ready) begin
               void'(exp2_q.pop_front());
               void'(exp2_sat_q.pop_front());
            end
         end
      end
   end

   initial begin
      int g;
      rst = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      in_data = '0; ign_sel = '0;
      s_out_ready = 1'b1; s_in_valid = 1'b0; s_in_first = 1'b0; s_in_last = 1'b0;
      s_in_data = '0; s_ign_sel = '0;
      #1 rst = 1'b1;
      #2;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_data", out_data, 128'(0));
      check("rst_out_sat", 128'(out_sat), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1 check("in_ready_after_rst", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      check("in_ready_first_clk", 128'(in_ready), 128'(1));

      // 16-bit accumulator overflow boundary
`ifdef LOA_ACCUM_SAT_EN
      exp2_q.push_back(16'h7FFF); exp2_sat_q.push_back(1'b1);
`else
      exp2_q.push_back(16'h8000); exp2_sat_q.push_back(1'b0);
`endif
      beat2(16'h7FFF, 1'b1, 1'b0);
      beat2(16'h0001, 1'b0, 1'b1);
      exp2_q.push_back(16'h0123); exp2_sat_q.push_back(1'b0);
      beat2(16'h0100, 1'b1, 1'b0);
      beat2(16'h0023, 1'b0, 1'b1);
      @(negedge clk); s_in_valid = 1'b0;

      // non-FIRST beat in IDLE is dropped
      beat(pk(16'd1000, 0, 0, 0), 1'b0, 1'b0, 4'd0);
      #1 check("discard_idle_busy", 128'(busy), 128'(0));

      // k=0 exact frame
      exp_q.push_back(ex(32'd17, 32'd13, 32'hFFFFFF6A, 32'h0001_7FFD)); exp_sat_q.push_back(4'h0);
      beat(pk(16'd7, 16'hFFFE, 16'd100, 16'h7FFF), 1'b1, 1'b0, 4'd0);
      beat(pk(16'd9, 16'd5, 16'hFED4, 16'h7FFF), 1'b0, 1'b0, 4'd0);
      #1 check("valid_before_last", 128'(out_valid), 128'(0));
      beat(pk(16'd1, 16'd10, 16'h0032, 16'h7FFF), 1'b0, 1'b1, 4'd0);
      #1 check("valid_latency", 128'(out_valid), 128'(1));

      // k=4, back-to-back with previous frame
      exp_q.push_back(ex(32'h0000000F, 32'hFFFFFFFF, 32'h60, 32'h28)); exp_sat_q.push_back(4'h0);
      beat(pk(16'd7, 16'hFFFF, 16'h10, 16'd8), 1'b1, 1'b0, 4'd4);
      beat(pk(16'd9, 16'd1, 16'h20, 16'd8), 1'b0, 1'b0, 4'd4);
      beat(pk(16'd1, 16'd0, 16'h30, 16'd8), 1'b0, 1'b1, 4'd4);

      // IGNORE_SEL=15 clamps to 8; mid-frame change ignored
      exp_q.push_back(ex(32'hFF, 32'h180, 32'h200, 32'hFFFFFFFF)); exp_sat_q.push_back(4'h0);
      beat(pk(16'hFF, 16'h80, 16'h100, 16'hFFFF), 1'b1, 1'b0, 4'd15);
      beat(pk(16'h01, 16'h80, 16'h100, 16'hFFFF), 1'b0, 1'b1, 4'd0);

      // FIRST mid-frame restarts and re-latches k
      exp_q.push_back(ex(32'd7, 32'h18, 32'd0, 32'd0)); exp_sat_q.push_back(4'h0);
      beat(pk(16'd50, 16'd1, 16'd1, 16'd1), 1'b1, 1'b0, 4'd0);
      beat(pk(16'd60, 16'd1, 16'd1, 16'd1), 1'b0, 1'b0, 4'd0);
      beat(pk(16'd3, 16'd8, 16'd0, 16'd0), 1'b1, 1'b0, 4'd4);
      beat(pk(16'd4, 16'd8, 16'd0, 16'd0), 1'b0, 1'b1, 4'd0);
      idle_in();
      repeat (2) @(negedge clk);

      // stall in HOLD, then handover with a new FIRST beat
      out_ready = 1'b0;
      exp_q.push_back(ex(32'd30, 32'd0, 32'd0, 32'd0)); exp_sat_q.push_back(4'h0);
      beat(pk(16'd10, 0, 0, 0), 1'b1, 1'b0, 4'd0);
      beat(pk(16'd20, 0, 0, 0), 1'b0, 1'b1, 4'd0);
      repeat (3) begin
         @(negedge clk); in_valid = 1'b0; #1;
         check("hold_in_ready", 128'(in_ready), 128'(0));
         check("hold_out_valid", 128'(out_valid), 128'(1));
      end
      exp_q.push_back(ex(32'd11, 32'd0, 32'd0, 32'd0)); exp_sat_q.push_back(4'h0);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = pk(16'd5, 0, 0, 0); in_first = 1'b1; in_last = 1'b0; ign_sel = 4'd0;
      #1 check("handover_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      check("handover_busy", 128'(busy), 128'(1));
      check("handover_valid_low", 128'(out_valid), 128'(0));
      beat(pk(16'd6, 0, 0, 0), 1'b0, 1'b1, 4'd0);
      idle_in();
      repeat (2) @(negedge clk);

      // reset mid-frame aborts with no output
      beat(pk(16'd1, 0, 0, 0), 1'b1, 1'b0, 4'd0);
      beat(pk(16'd2, 0, 0, 0), 1'b0, 1'b0, 4'd0);
      #2 rst = 1'b1;
      #1;
      check("abort_out_valid", 128'(out_valid), 128'(0));
      check("abort_busy", 128'(busy), 128'(0));
      check("abort_in_ready", 128'(in_ready), 128'(0));
      check("abort_acc", out_data, 128'(0));
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk);
      exp_q.push_back(ex(32'd5, 32'd0, 32'd0, 32'd0)); exp_sat_q.push_back(4'h0);
      beat(pk(16'd2, 0, 0, 0), 1'b1, 1'b0, 4'd0);
      beat(pk(16'd3, 0, 0, 0), 1'b0, 1'b1, 4'd0);
      idle_in();

      g = 0;
      while ((exp_q.size() != 0 || exp2_q.size() != 0) && g < 200) begin
         @(negedge clk); g++;
      end
      check("drain_main", 128'(exp_q.size()), 128'(0));
      check("drain_narrow", 128'(exp2_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
